// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: joystick bit layout, PS/2 key codes,
// SOCD mode encoding and the key-state to joystick-word helper.
package arcade_input_pkg;

  localparam int JOY_R     = 0;
  localparam int JOY_L     = 1;
  localparam int JOY_D     = 2;
  localparam int JOY_U     = 3;
  localparam int JOY_FIRE  = 4;
  localparam int JOY_START = 8;
  localparam int JOY_COIN  = 9;

  // Keyboard state bits per player; fire0 has two keys on player 0 so they are held apart
  localparam int KEY_BITS = 9;
  localparam int K_R      = 0;
  localparam int K_L      = 1;
  localparam int K_D      = 2;
  localparam int K_U      = 3;
  localparam int K_F0A    = 4;
  localparam int K_F0B    = 5;
  localparam int K_F1     = 6;
  localparam int K_START  = 7;
  localparam int K_COIN   = 8;

  localparam logic [7:0] KC_UP    = 8'h75;
  localparam logic [7:0] KC_DOWN  = 8'h72;
  localparam logic [7:0] KC_LEFT  = 8'h6B;
  localparam logic [7:0] KC_RIGHT = 8'h74;

  localparam logic [8:0] KC_P0_F0A   = 9'h029;
  localparam logic [8:0] KC_P0_F0B   = 9'h014;
  localparam logic [8:0] KC_P0_F1    = 9'h011;
  localparam logic [8:0] KC_P0_START = 9'h016;
  localparam logic [8:0] KC_P0_COIN  = 9'h02E;

  localparam logic [8:0] KC_P1_U     = 9'h02D;
  localparam logic [8:0] KC_P1_D     = 9'h02B;
  localparam logic [8:0] KC_P1_L     = 9'h023;
  localparam logic [8:0] KC_P1_R     = 9'h034;
  localparam logic [8:0] KC_P1_F0    = 9'h01C;
  localparam logic [8:0] KC_P1_F1    = 9'h01B;
  localparam logic [8:0] KC_P1_START = 9'h01E;
  localparam logic [8:0] KC_P1_COIN  = 9'h036;

  typedef enum logic [1:0] {
    SOCD_PASS    = 2'd0,
    SOCD_NEUTRAL = 2'd1,
    SOCD_LAST    = 2'd2
  } socd_mode_e;

  function automatic logic [15:0] key_to_joy(input logic [KEY_BITS-1:0] k);
    logic [15:0] w;
    w              = '0;
    w[JOY_R]       = k[K_R];
    w[JOY_L]       = k[K_L];
    w[JOY_D]       = k[K_D];
    w[JOY_U]       = k[K_U];
    w[JOY_FIRE]    = k[K_F0A] | k[K_F0B];
    w[JOY_FIRE+1]  = k[K_F1];
    w[JOY_START]   = k[K_START];
    w[JOY_COIN]    = k[K_COIN];
    return w;
  endfunction

endpackage

// File: rtl/arcade_player_cond.sv
// Per-player output conditioning: SOCD cleaning per axis, autofire on fire0,
// coin pulse stretcher, and the registered outputs.
module arcade_player_cond
  import arcade_input_pkg::*;
#(
  parameter int N_BTN        = 2,
  parameter int SOCD_MODE    = 2,
  parameter int AUTOFIRE_DIV = 4_000_000,
  parameter int COIN_PULSE   = 400_000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [3:0]       raw_dir,
  input  logic [N_BTN-1:0] raw_fire,
  input  logic             raw_start,
  input  logic             raw_coin,
  input  logic             autofire_en,
  output logic [3:0]       dir,
  output logic [N_BTN-1:0] fire,
  output logic             start,
  output logic             coin
);

  localparam int AF_W = $clog2(AUTOFIRE_DIV + 1);
  localparam int CP_W = $clog2(COIN_PULSE + 1);

  // Axis 0 pairs R(a)/L(b), axis 1 pairs D(a)/U(b); last_b=1 means b rose most recently
  logic [1:0] ra, rb, prev_a, prev_b, rise_a, rise_b;
  logic [1:0] last_b, last_b_nxt;
  logic [3:0] dir_nxt;

  assign ra     = {raw_dir[JOY_D], raw_dir[JOY_R]};
  assign rb     = {raw_dir[JOY_U], raw_dir[JOY_L]};
  assign rise_a = ra & ~prev_a;
  assign rise_b = rb & ~prev_b;

  always_comb begin
    last_b_nxt = last_b;
    dir_nxt    = raw_dir;
    for (int ax = 0; ax < 2; ax++) begin
      if (rise_a[ax] && !rise_b[ax])
        last_b_nxt[ax] = 1'b0;
      else if (rise_b[ax] && !rise_a[ax])
        last_b_nxt[ax] = 1'b1;
      if (ra[ax] && rb[ax]) begin
        if (SOCD_MODE == int'(SOCD_NEUTRAL))
          dir_nxt[2*ax +: 2] = 2'b00;
        else if (SOCD_MODE == int'(SOCD_LAST))
          dir_nxt[2*ax +: 2] = last_b_nxt[ax] ? 2'b10 : 2'b01;
      end
    end
  end

  // af_blk keeps a fire0 held through reset from autofiring until it is released
  logic [AF_W-1:0]  af_cnt, af_cnt_nxt;
  logic             af_on, af_on_nxt, af_blk;
  logic [N_BTN-1:0] fire_nxt;

  always_comb begin
    af_cnt_nxt = af_cnt;
    af_on_nxt  = af_on;
    if (!autofire_en || !raw_fire[0] || af_blk) begin
      af_cnt_nxt = '0;
      af_on_nxt  = 1'b0;
    end else if (af_cnt == '0) begin
      af_on_nxt  = 1'b1;
      af_cnt_nxt = AF_W'(1);
    end else if (af_cnt == AF_W'(AUTOFIRE_DIV)) begin
      af_on_nxt  = ~af_on;
      af_cnt_nxt = AF_W'(1);
    end else begin
      af_cnt_nxt = af_cnt + 1'b1;
    end
  end

  always_comb begin
    fire_nxt    = raw_fire;
    fire_nxt[0] = autofire_en ? af_on_nxt : raw_fire[0];
  end

  logic            coin_prev;
  logic [CP_W-1:0] coin_cnt;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      prev_a    <= '0;
      prev_b    <= '0;
      last_b    <= '0;
      af_cnt    <= '0;
      af_on     <= 1'b0;
      af_blk    <= 1'b1;
      coin_prev <= 1'b1;
      coin_cnt  <= '0;
      dir       <= '0;
      fire      <= '0;
      start     <= 1'b0;
      coin      <= 1'b0;
    end else begin
      prev_a    <= ra;
      prev_b    <= rb;
      last_b    <= last_b_nxt;
      af_cnt    <= af_cnt_nxt;
      af_on     <= af_on_nxt;
      af_blk    <= af_blk & raw_fire[0];
      dir       <= dir_nxt;
      fire      <= fire_nxt;
      start     <= raw_start;
      coin_prev <= raw_coin;
      if (coin) begin
        if (coin_cnt == CP_W'(COIN_PULSE)) begin
          coin     <= 1'b0;
          coin_cnt <= '0;
        end else begin
          coin_cnt <= coin_cnt + 1'b1;
        end
      end else if (raw_coin && !coin_prev) begin
        coin     <= 1'b1;
        coin_cnt <= CP_W'(1);
      end
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key events and HPS joysticks into per-player arcade controls.
// Holds key decode, key state and joystick merge; per-player conditioning is in arcade_player_cond.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int N_BTN        = 2,
  parameter int SOCD_MODE    = 2,
  parameter int AUTOFIRE_DIV = 4_000_000,
  parameter int COIN_PULSE   = 400_000
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [10:0]                ps2_key,
  input  logic [16*N_PLAYERS-1:0]    joy_in,
  input  logic                       merge_joys,
  input  logic [N_PLAYERS-1:0]       autofire_en,
  output logic [4*N_PLAYERS-1:0]     dir_out,
  output logic [N_BTN*N_PLAYERS-1:0] fire_out,
  output logic [N_PLAYERS-1:0]       start_out,
  output logic [N_PLAYERS-1:0]       coin_out
);

  logic                      shadow, evt;
  logic [8:0]                kcode;
  logic [7:0]                kbase;
  logic [1:0][KEY_BITS-1:0]  key_q, hit;
  logic [15:0]               joy_or;

  assign kcode = ps2_key[8:0];
  assign kbase = ps2_key[7:0];
  assign evt   = ps2_key[10] ^ shadow;

  // Arrows ignore the extended flag; everything else needs the exact 9-bit code
  always_comb begin
    hit                = '0;
    hit[0][K_U]        = (kbase == KC_UP);
    hit[0][K_D]        = (kbase == KC_DOWN);
    hit[0][K_L]        = (kbase == KC_LEFT);
    hit[0][K_R]        = (kbase == KC_RIGHT);
    hit[0][K_F0A]      = (kcode == KC_P0_F0A);
    hit[0][K_F0B]      = (kcode == KC_P0_F0B);
    hit[0][K_F1]       = (kcode == KC_P0_F1);
    hit[0][K_START]    = (kcode == KC_P0_START);
    hit[0][K_COIN]     = (kcode == KC_P0_COIN);
    hit[1][K_U]        = (kcode == KC_P1_U);
    hit[1][K_D]        = (kcode == KC_P1_D);
    hit[1][K_L]        = (kcode == KC_P1_L);
    hit[1][K_R]        = (kcode == KC_P1_R);
    hit[1][K_F0A]      = (kcode == KC_P1_F0);
    hit[1][K_F1]       = (kcode == KC_P1_F1);
    hit[1][K_START]    = (kcode == KC_P1_START);
    hit[1][K_COIN]     = (kcode == KC_P1_COIN);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      shadow <= ps2_key[10];
      key_q  <= '0;
    end else begin
      shadow <= ps2_key[10];
      if (evt) begin
        for (int p = 0; p < 2; p++)
          for (int b = 0; b < KEY_BITS; b++)
            if (hit[p][b]) key_q[p][b] <= ps2_key[9];
      end
    end
  end

  always_comb begin
    joy_or = '0;
    for (int p = 0; p < N_PLAYERS; p++)
      joy_or = joy_or | joy_in[16*p +: 16];
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    logic [15:0] key_w, raw;
    logic        unused_raw;

    if (p < 2) begin : g_kb
      assign key_w = key_to_joy(key_q[p]);
    end else begin : g_nokb
      assign key_w = '0;
    end

    assign raw        = key_w | (merge_joys ? joy_or : joy_in[16*p +: 16]);
    assign unused_raw = ^raw;

    arcade_player_cond #(
      .N_BTN        (N_BTN),
      .SOCD_MODE    (SOCD_MODE),
      .AUTOFIRE_DIV (AUTOFIRE_DIV),
      .COIN_PULSE   (COIN_PULSE)
    ) u_cond (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .raw_dir     (raw[3:0]),
      .raw_fire    (raw[JOY_FIRE +: N_BTN]),
      .raw_start   (raw[JOY_START]),
      .raw_coin    (raw[JOY_COIN]),
      .autofire_en (autofire_en[p]),
      .dir         (dir_out[4*p +: 4]),
      .fire        (fire_out[N_BTN*p +: N_BTN]),
      .start       (start_out[p]),
      .coin        (coin_out[p])
    );
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: 2 players, 2 buttons, last-pressed SOCD,
// autofire half-period 4, coin pulse 8.
module tb_arcade_input_mapper;

  localparam int NP = 2;
  localparam int NB = 2;

  logic            clk_sys = 1'b0;
  logic            reset_n;
  logic [10:0]     ps2_key;
  logic [16*NP-1:0] joy_in;
  logic            merge_joys;
  logic [NP-1:0]   autofire_en;
  logic [4*NP-1:0] dir_out;
  logic [NB*NP-1:0] fire_out;
  logic [NP-1:0]   start_out;
  logic [NP-1:0]   coin_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .N_PLAYERS(NP), .N_BTN(NB), .SOCD_MODE(2), .AUTOFIRE_DIV(4), .COIN_PULSE(8)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_in),
    .merge_joys(merge_joys), .autofire_en(autofire_en), .dir_out(dir_out),
    .fire_out(fire_out), .start_out(start_out), .coin_out(coin_out)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic test_reset();
    logic [15:0] all;
    // toggle bit high with E075 pressed: a spurious event would light P0 up
    ps2_key = {1'b1, 1'b1, 9'h175};
    joy_in = '0; merge_joys = 1'b0; autofire_en = '0;
    reset_n = 1'b0;
    tick(3);
    all = {dir_out, fire_out, start_out, coin_out};
    checks++;
    if (all !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0000", all);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      all = {dir_out, fire_out, start_out, coin_out};
      checks++;
      if (all !== 16'h0) begin
        errors++; $display("FAIL reset_release_idle cyc%0d: got %h expected 0000", i, all);
      end
    end
  endtask

  task automatic test_socd();
    joy_in[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dir_out !== 8'h02) begin
        errors++; $display("FAIL socd_left_only cyc%0d: got %h expected 02", i, dir_out);
      end
    end
    joy_in[0] = 1'b1;
    tick();
    checks++;
    if (dir_out !== 8'h01) begin
      errors++; $display("FAIL socd_right_wins: got %h expected 01", dir_out);
    end
    tick(2);
    checks++;
    if (dir_out !== 8'h01) begin
      errors++; $display("FAIL socd_right_holds: got %h expected 01", dir_out);
    end
    joy_in[0] = 1'b0;
    tick();
    checks++;
    if (dir_out !== 8'h02) begin
      errors++; $display("FAIL socd_handover: got %h expected 02", dir_out);
    end
    joy_in[1] = 1'b0;
    tick();
    checks++;
    if (dir_out !== 8'h00) begin
      errors++; $display("FAIL socd_release: got %h expected 00", dir_out);
    end
    // D alone first, then U+D rising together keeps D as the winner
    joy_in[2] = 1'b1;
    tick();
    joy_in[2] = 1'b0;
    tick();
    joy_in[3:2] = 2'b11;
    tick();
    checks++;
    if (dir_out !== 8'h04) begin
      errors++; $display("FAIL socd_simultaneous: got %h expected 04", dir_out);
    end
    joy_in[3:2] = 2'b00;
    tick(2);
  endtask

  task automatic test_ps2_keys();
    send_key(1'b1, 9'h175);
    tick();
    checks++;
    if (dir_out !== 8'h00) begin
      errors++; $display("FAIL ps2_press_lat1: got %h expected 00", dir_out);
    end
    tick();
    checks++;
    if (dir_out !== 8'h08) begin
      errors++; $display("FAIL ps2_up_press: got %h expected 08", dir_out);
    end
    send_key(1'b0, 9'h175);
    tick();
    checks++;
    if (dir_out !== 8'h08) begin
      errors++; $display("FAIL ps2_release_lat1: got %h expected 08", dir_out);
    end
    tick();
    checks++;
    if (dir_out !== 8'h00) begin
      errors++; $display("FAIL ps2_up_release: got %h expected 00", dir_out);
    end
    send_key(1'b1, 9'h114);
    tick(2);
    checks++;
    if (fire_out !== 4'h0) begin
      errors++; $display("FAIL ps2_ext_mismatch: got %h expected 0", fire_out);
    end
    send_key(1'b1, 9'h014);
    tick(2);
    checks++;
    if (fire_out !== 4'h1) begin
      errors++; $display("FAIL ps2_lctrl_fire0: got %h expected 1", fire_out);
    end
    send_key(1'b0, 9'h014);
    tick(2);
    send_key(1'b1, 9'h01E);
    tick(2);
    checks++;
    if ({fire_out, start_out} !== 6'b0000_10) begin
      errors++; $display("FAIL ps2_p1_start: got %b expected 000010", {fire_out, start_out});
    end
    send_key(1'b0, 9'h01E);
    tick(2);
    checks++;
    if (start_out !== 2'b00) begin
      errors++; $display("FAIL ps2_p1_start_rel: got %b expected 00", start_out);
    end
  endtask

  task automatic test_coin();
    int high, edges;
    logic prev, first;
    joy_in[9] = 1'b1;
    high = 0; edges = 0; prev = 1'b0; first = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 0) first = coin_out[0];
      if (coin_out[0]) high++;
      if (coin_out[0] && !prev) edges++;
      prev = coin_out[0];
    end
    checks++;
    if (first !== 1'b1) begin
      errors++; $display("FAIL coin_latency: got %b expected 1", first);
    end
    checks++;
    if (high != 8 || edges != 1) begin
      errors++; $display("FAIL coin_held_pulse: got %0d high/%0d pulses expected 8/1", high, edges);
    end
    joy_in[9] = 1'b0;
    tick(3);
    // second press with a release/re-press blip while the pulse is running
    joy_in[9] = 1'b1;
    high = 0; edges = 0; prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) joy_in[9] = 1'b0;
      if (i == 4) joy_in[9] = 1'b1;
      tick();
      if (coin_out[0]) high++;
      if (coin_out[0] && !prev) edges++;
      prev = coin_out[0];
    end
    checks++;
    if (high != 8 || edges != 1 || coin_out[1] !== 1'b0) begin
      errors++; $display("FAIL coin_repress: got %0d high/%0d pulses/p1 %b expected 8/1/0", high, edges, coin_out[1]);
    end
    joy_in[9] = 1'b0;
    tick(2);
    // reset mid-pulse with coin still held
    joy_in[9] = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick();
    checks++;
    if (coin_out !== 2'b00) begin
      errors++; $display("FAIL coin_reset_mid_pulse: got %b expected 00", coin_out);
    end
    reset_n = 1'b1;
    high = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (coin_out[0]) high++;
    end
    checks++;
    if (high != 0) begin
      errors++; $display("FAIL coin_held_through_reset: got %0d high expected 0", high);
    end
    joy_in[9] = 1'b0;
    tick();
    joy_in[9] = 1'b1;
    tick();
    checks++;
    if (coin_out !== 2'b01) begin
      errors++; $display("FAIL coin_after_reset: got %b expected 01", coin_out);
    end
    joy_in[9] = 1'b0;
    tick(10);
  endtask

  task automatic test_autofire();
    logic       exp;
    logic [3:0] want;
    autofire_en = 2'b10;
    tick();
    send_key(1'b1, 9'h01C);
    tick();
    checks++;
    if (fire_out !== 4'h0) begin
      errors++; $display("FAIL af_latency: got %h expected 0", fire_out);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      exp  = ((k / 4) % 2) == 0;
      want = {1'b0, exp, 2'b00};
      checks++;
      if (fire_out !== want) begin
        errors++; $display("FAIL af_pattern k%0d: got %h expected %h", k, fire_out, want);
      end
    end
    send_key(1'b0, 9'h01C);
    tick(2);
    checks++;
    if (fire_out !== 4'h0) begin
      errors++; $display("FAIL af_release: got %h expected 0", fire_out);
    end
    autofire_en = 2'b00;
    tick();
  endtask

  task automatic test_merge();
    joy_in = '0;
    joy_in[16+4] = 1'b1;
    merge_joys = 1'b1;
    tick();
    checks++;
    if (fire_out !== 4'b0101) begin
      errors++; $display("FAIL merge_on: got %b expected 0101", fire_out);
    end
    merge_joys = 1'b0;
    tick();
    checks++;
    if (fire_out !== 4'b0100) begin
      errors++; $display("FAIL merge_off: got %b expected 0100", fire_out);
    end
    joy_in = '0;
    joy_in[8] = 1'b1;
    tick();
    checks++;
    if ({fire_out, start_out} !== 6'b0000_01) begin
      errors++; $display("FAIL joy_start: got %b expected 000001", {fire_out, start_out});
    end
    joy_in = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_socd();
    test_ps2_keys();
    test_coin();
    test_autofire();
    test_merge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
